// File: rtl/input_cond_pkg.sv
// input_cond_pkg
// Shared constants and helpers for the input conditioning blocks
// (synchroniser + debounce filter).
//
// Contents:
//   SYNC_STAGES_DEF     - default synchroniser depth
//   DEBOUNCE_CYCLES_DEF - default number of enabled mismatch samples to accept a level
//   CNT_W_DEF           - default stability counter width
//   min_cnt_w()         - smallest counter width able to hold DEBOUNCE_CYCLES-1
package input_cond_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int CNT_W_DEF           = 4;

  // The counter only ever reaches cycles-1, so the width w must satisfy
  // 2**w >= cycles. A width of at least 1 is always returned.
  function automatic int min_cnt_w(input int cycles);
    int w;
    w = 1;
    while ((1 << w) < cycles) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/input_debounce_sync_chain.sv
// sync_chain
// Plain N-flop shift chain used to bring an asynchronous level into clk.
// Only the first flop ever samples d; q is the output of the last flop.
//
// Ports:
//   clk - system clock, all flops on posedge
//   rst - synchronous active-high reset, clears every stage to 0
//   d   - asynchronous input
//   q   - synchronised output (last stage)
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// input_debounce
// Synchronises a raw asynchronous input, filters bounce/glitches with a
// stability counter, and produces a clean level plus one-cycle edge pulses.
// The output level q is registered and safe to feed straight into capture flops.
//
// Ports:
//   clk  - system clock, all logic on posedge
//   rst  - synchronous active-high reset, overrides en and every other input
//   din  - raw asynchronous input (switch or pin)
//   en   - sample-enable tick; filter only advances when high
//   q    - debounced, synchronised level
//   rise - one-cycle pulse in the cycle q first shows 1
//   fall - one-cycle pulse in the cycle q first shows 0
//   busy - high while the stability counter is non-zero (change pending)
//
// There is no valid/ready handshake here: en is a plain qualifier that is
// sampled every posedge, and rise/fall are unconditional single-cycle strobes
// that the consumer must take in the cycle they are high.
module input_debounce
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Terminal count: the DEBOUNCE_CYCLES-th consecutive mismatch is the one
  // that commits, so the counter never holds more than DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             q_next;
  logic             rise_next;
  logic             fall_next;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  always_comb begin
    cnt_next  = cnt;
    q_next    = q;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (en) begin
      if (s == q) begin
        // Any matching sample abandons the candidate change.
        cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
        q_next    = s;
        cnt_next  = '0;
        rise_next = s;
        fall_next = ~s;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // busy is registered from cnt_next so it always equals (cnt != 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      q    <= q_next;
      rise <= rise_next;
      fall <= fall_next;
      busy <= (cnt_next != '0);
    end
  end

endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce
// Self-checking bench for input_debounce with default parameters
// (2 sync stages, 8 debounce cycles). Expected edge pulses are pushed as
// {kind, edge number} when stimulus is applied; a negedge monitor records
// observed pulses and each scenario task compares the two queues.
module tb_input_debounce;

  localparam int W = 34;
  localparam logic [1:0] K_RISE = 2'b01;
  localparam logic [1:0] K_FALL = 2'b10;

  logic clk;
  logic rst;
  logic din;
  logic en;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  logic en_manual;
  logic gate_mode;

  int unsigned edge_n = 0;
  int checks = 0;
  int errors = 0;
  logic prev_pulse = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #4 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // en = one tick in four while gate_mode is set.
  assign en = gate_mode ? (edge_n[1:0] == 2'b00) : en_manual;

  input_debounce dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .en   (en),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rise || fall) begin
      obs_q.push_back({fall, rise, edge_n});
      checks++;
      if ((rise && fall) || prev_pulse) begin
        errors++;
        $display("FAIL pulse_shape: edge=%0d rise=%b fall=%b prev_pulse=%b, required single isolated pulse",
                 edge_n, rise, fall, prev_pulse);
      end
    end
    prev_pulse = rise || fall;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver helpers ----------------
  // Advance n posedges and settle 2 ns past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int unsigned base;
    logic [W-1:0] e, o;
    exp_q.delete();
    rst = 1'b1; din = 1'b1; en_manual = 1'b1; gate_mode = 1'b0;
    tick(2);
    obs_q.delete();
    checks++;
    if ({q, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values: q/rise/fall/busy=%b, required 0000", {q, rise, fall, busy});
    end
    rst = 1'b0;
    base = edge_n;
    exp_q.push_back({K_RISE, 32'(base + 10)});
    tick(9);
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL reset_q_early: q=%b at edge %0d, required 0", q, edge_n);
    end
    tick(1);
    checks++;
    if (q !== 1'b1 || rise !== 1'b1) begin
      errors++;
      $display("FAIL reset_q_release: q=%b rise=%b at edge %0d, required q=1 rise=1", q, rise, edge_n);
    end
    tick(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_count: %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_event: kind=%b edge=%0d, required kind=%b edge=%0d", o[33:32], o[31:0], e[33:32], e[31:0]);
      end
    end
  endtask

  task automatic test_step();
    int unsigned base;
    logic [W-1:0] e, o;
    exp_q.delete(); obs_q.delete();
    // 1 -> 0 first, bringing q back to 0
    din = 1'b0;
    base = edge_n;
    exp_q.push_back({K_FALL, 32'(base + 10)});
    tick(10);
    checks++;
    if (q !== 1'b0 || fall !== 1'b1) begin
      errors++;
      $display("FAIL step_fall: q=%b fall=%b at edge %0d, required q=0 fall=1", q, fall, edge_n);
    end
    tick(3);
    // clean 0 -> 1 with busy timing
    din = 1'b1;
    base = edge_n;
    exp_q.push_back({K_RISE, 32'(base + 10)});
    tick(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL step_busy_e2: busy=%b, required 0", busy);
    end
    tick(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL step_busy_e3: busy=%b, required 1", busy);
    end
    tick(6);
    checks++;
    if (busy !== 1'b1 || q !== 1'b0) begin
      errors++;
      $display("FAIL step_e9: busy=%b q=%b, required busy=1 q=0", busy, q);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0 || q !== 1'b1 || rise !== 1'b1) begin
      errors++;
      $display("FAIL step_e10: busy=%b q=%b rise=%b, required 0 1 1", busy, q, rise);
    end
    tick(1);
    checks++;
    if (rise !== 1'b0) begin
      errors++;
      $display("FAIL step_rise_width: rise=%b at edge 11, required 0", rise);
    end
    tick(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL step_count: %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL step_event: kind=%b edge=%0d, required kind=%b edge=%0d", o[33:32], o[31:0], e[33:32], e[31:0]);
      end
    end
    // return to 0 for the glitch test
    din = 1'b0;
    tick(14);
    obs_q.delete();
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL step_return: q=%b, required 0", q);
    end
  endtask

  task automatic test_glitch();
    exp_q.delete(); obs_q.delete();
    din = 1'b1;
    tick(5);
    din = 1'b0;
    tick(15);
    checks++;
    if (q !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_level: q=%b busy=%b, required q=0 busy=0", q, busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL glitch_count: %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_bounce();
    int unsigned base;
    logic [W-1:0] e, o;
    exp_q.delete(); obs_q.delete();
    din = 1'b1; tick(1);
    din = 1'b0; tick(1);
    din = 1'b1; tick(1);
    din = 1'b0; tick(1);
    din = 1'b1;
    base = edge_n;
    exp_q.push_back({K_RISE, 32'(base + 10)});
    tick(16);
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL bounce_level: q=%b, required 1", q);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bounce_count: %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bounce_event: kind=%b edge=%0d, required kind=%b edge=%0d", o[33:32], o[31:0], e[33:32], e[31:0]);
      end
    end
  endtask

  task automatic test_enable_gating();
    int unsigned base;
    int unsigned k;
    int n;
    logic [W-1:0] e, o;
    exp_q.delete(); obs_q.delete();
    gate_mode = 1'b1;
    din = 1'b0;
    base = edge_n;
    // Model: s is new from edge base+2; edge k samples en driven from edge k-1.
    k = base + 3;
    n = 0;
    while (n < 8) begin
      if (((k - 1) % 4) == 0) n++;
      if (n < 8) k++;
    end
    exp_q.push_back({K_FALL, 32'(k)});
    tick(20);
    checks++;
    if (busy !== 1'b1 || q !== 1'b1) begin
      errors++;
      $display("FAIL gate_mid: busy=%b q=%b, required busy=1 q=1", busy, q);
    end
    tick(int'(k - edge_n) + 3);
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL gate_level: q=%b, required 0", q);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gate_count: %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL gate_event: kind=%b edge=%0d, required kind=%b edge=%0d", o[33:32], o[31:0], e[33:32], e[31:0]);
      end
    end
    gate_mode = 1'b0;
    en_manual = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid_count();
    int unsigned base;
    logic [W-1:0] e, o;
    exp_q.delete(); obs_q.delete();
    din = 1'b1;
    tick(7);  // cnt = 5 after edge base+7
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({q, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_values: q/rise/fall/busy=%b, required 0000", {q, rise, fall, busy});
    end
    rst = 1'b0;
    base = edge_n;
    exp_q.push_back({K_RISE, 32'(base + 10)});
    tick(9);
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: q=%b at edge 9 after release, required 0", q);
    end
    tick(4);
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL midrst_final: q=%b, required 1", q);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_count: %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midrst_event: kind=%b edge=%0d, required kind=%b edge=%0d", o[33:32], o[31:0], e[33:32], e[31:0]);
      end
    end
  endtask

  // Random short glitches (< 8 samples) on a settled 1 level must not move q.
  task automatic test_random_glitches();
    int len;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(1, 5);
      din = 1'b0;
      tick(len);
      din = 1'b1;
      tick($urandom_range(1, 3));
    end
    tick(12);
    checks++;
    if (q !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_glitch_level: q=%b busy=%b, required q=1 busy=0", q, busy);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rand_glitch_count: %0d pulses, required 0", obs_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; din = 1'b0; en_manual = 1'b1; gate_mode = 1'b0;
    test_reset();
    test_step();
    test_glitch();
    test_bounce();
    test_enable_gating();
    test_reset_mid_count();
    test_random_glitches();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Front-end conditioning stage that sits directly upstream of the capture flops (DFF) and drives their d input.
- Synchronises an asynchronous raw input into clk, filters glitches with a stability counter, and outputs a clean level plus one-cycle edge pulses.
- Its output is safe to register downstream with no metastability or bounce.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range ≥2.
- CNT_W, 4, width of the stability counter.
- DEBOUNCE_CYCLES, 8, consecutive enabled mismatch samples needed to accept a new level; legal range 1..2^CNT_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  raw asynchronous input (switch or pin).
- en  input  1  sample-enable tick; a prescaler may drive it, or tie it high.
- q  output  1  debounced, synchronised level.
- rise  output  1  one-cycle pulse when q goes 0->1.
- fall  output  1  one-cycle pulse when q goes 1->0.
- busy  output  1  high while the counter is non-zero, meaning a candidate change is pending.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and takes priority over en and every other input.
- Reset values: every sync flop, cnt, q, rise, fall and busy go to 0 at the first posedge with rst=1. Reset mid-count discards the pending change.
- Sync chain:
  - Shifts din on every posedge regardless of en.
  - s is the last stage output.
  - Only the first stage may sample din; nothing else looks at din.
- Filter, per posedge with rst=0 and en=1:
  - If s==q: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: q<=s, cnt<=0, and rise<=s or fall<=~s.
  - Else: cnt<=cnt+1.
- en=0: cnt and q hold. rise and fall are 0 on every cycle where q does not change.
- Pulses: registered, and asserted in exactly the cycle q first shows its new value. Never both high. Never high for two consecutive cycles.
- busy: registered, equal to (cnt!=0).
- Latency with en=1 constantly:
  - din stable before edge 1 gives q updated at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Default is 10 edges, i.e. 80 ns at an 8 ns period.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES enabled samples never changes q. Any single matching sample restarts the count from 0.
- DEBOUNCE_CYCLES=1: q follows s one enabled cycle later, with no filtering.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- After reset with din held at 1: q rises after normal latency and rise pulses once.

Decomposition:
- Shared package input_cond_pkg holds:
  - default constants SYNC_STAGES_DEF=2, DEBOUNCE_CYCLES_DEF=8, CNT_W_DEF=4;
  - a function computing the minimum CNT_W for a given DEBOUNCE_CYCLES.
- One sub-module, sync_chain:
  - parameter SYNC_STAGES;
  - ports clk, rst, d, q;
  - a plain N-flop shift chain with synchronous reset to 0.
- input_debounce instantiates sync_chain and holds the counter and edge logic.

Test Plan:
- Reset: rst=1 for 2 edges with din=1 -> q, rise, fall, busy all 0. Release -> q=1 at edge 10 after release, rise high for exactly that cycle.
- Clean step: din 0->1 settled before edge 1, en=1 -> busy high from edge 3 to edge 9, q=1 at edge 10, rise=1 for one cycle. Then din 1->0 -> q=0 after 10 edges, with a single fall pulse.
- Glitch: din=1 for 5 clocks (40 ns), then back to 0 -> q stays 0, no rise, busy returns to 0.
- Bounce: din toggles 1,0,1,0 at 1-clock spacing, then settles at 1 -> exactly one rise, occurring 10 edges after the final settle.
- Enable gating: en high 1 cycle in 4 -> q changes 2+8*4=34 edges after a settled step (±3 for en phase). cnt holds while en=0.
- Reset mid-count: assert rst when cnt=5 -> next cycle cnt=0, busy=0, q unchanged at 0, no pulse. After release the step completes with full latency.
